// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//   Feeds the per-digit seven-segment decoders. The published result is held
//   stable between conversions, so intermediate accumulator values are never
//   visible on bcd. Nibble code 4'hF is used for blanked / out-of-range digits.
//
// Parameters
//   BIN_W   width of the binary input (2**BIN_W must be >= 10**DIGITS)
//   DIGITS  number of BCD output digits
//   LZB     1 = blank leading zero digits (digit 0 is never blanked)
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, only honoured while idle
//   bin    in   unsigned value, captured on the accepted start edge
//   busy   out  conversion in progress
//   done   out  one-cycle pulse when bcd/ovf have been updated
//   ovf    out  last captured value exceeded 10**DIGITS-1
//   bcd    out  packed BCD result, digit 0 in bits [3:0]
// ---------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4,
    parameter int LZB    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned LIMIT_I = 10**DIGITS - 1;
    localparam logic [BIN_W-1:0] LIMIT = BIN_W'(LIMIT_I);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BIN_W-1:0]       r_sh;
    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_range;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_ovf;
    logic [ACC_W-1:0]       r_bcd;

    logic [ACC_W-1:0]       w_acc_adj;
    logic [ACC_W+BIN_W-1:0] w_shifted;
    logic [ACC_W-1:0]       w_result;

    // Add 3 to every nibble that is 5 or more; each nibble is independent,
    // a digit never carries into its neighbour.
    function automatic logic [ACC_W-1:0] add3_nibbles(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] res;
        res = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end else begin
                res[4*d +: 4] = acc[4*d +: 4];
            end
        end
        return res;
    endfunction

    // Replace zero digits with 4'hF from the top down until the first
    // nonzero digit; digit 0 is excluded so a zero value still shows "0".
    function automatic logic [ACC_W-1:0] blank_leading(input logic [ACC_W-1:0] acc);
        logic [ACC_W-1:0] res;
        logic             leading;
        res     = acc;
        leading = 1'b1;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            if (leading && (acc[4*d +: 4] == 4'd0)) begin
                res[4*d +: 4] = 4'hF;
            end else begin
                leading = 1'b0;
            end
        end
        return res;
    endfunction

    assign w_acc_adj = add3_nibbles(r_acc);
    // Accumulator and shift register move as one wide register; the bit
    // falling off the top is always zero for in-range values.
    assign w_shifted = {w_acc_adj, r_sh} << 1;
    assign w_result  = (LZB != 0) ? blank_leading(r_acc) : r_acc;

    assign busy = r_busy;
    assign done = r_done;
    assign ovf  = r_ovf;
    assign bcd  = r_bcd;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> SHIFT on start, BIN_W iterations, then LOAD.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs: capture, iterate, publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh    <= {BIN_W{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_range <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_bcd   <= {ACC_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sh    <= bin;
                        r_acc   <= {ACC_W{1'b0}};
                        r_cnt   <= {CNT_W{1'b0}};
                        r_range <= (bin > LIMIT);
                        r_busy  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    r_done           <= 1'b0;
                    {r_acc, r_sh}    <= w_shifted;
                    r_cnt            <= r_cnt + CNT_W'(1);
                end
                ST_LOAD: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    if (r_range) begin
                        r_bcd <= {ACC_W{1'b1}};
                        r_ovf <= 1'b1;
                    end else begin
                        r_bcd <= w_result;
                        r_ovf <= 1'b0;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [13:0] bin_a, bin_b;
    logic        busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [15:0] bcd_a, bcd_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] q_a[$];
    logic [16:0] q_b[$];

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .LZB(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
        .busy(busy_a), .done(done_a), .ovf(ovf_a), .bcd(bcd_a));

    bin2bcd_seq #(.BIN_W(14), .DIGITS(4), .LZB(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
        .busy(busy_b), .done(done_b), .ovf(ovf_b), .bcd(bcd_b));

    always #5 clk = ~clk;

    // Reference model: decimal digits by division, {ovf, bcd}.
    function automatic logic [16:0] model(input int v, input bit lzb);
        logic [15:0] r;
        bit          lead;
        int          t;
        if (v > 9999) return {1'b1, 16'hFFFF};
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        if (lzb) begin
            lead = 1'b1;
            for (int i = 3; i >= 1; i--) begin
                if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
        return {1'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse (the following edge is E0) and queue the expectation.
    task automatic start_conv(input bit sel, input int v);
        if (sel) begin
            start_b = 1'b1; bin_b = 14'(v); q_b.push_back(model(v, 1'b1));
        end else begin
            start_a = 1'b1; bin_a = 14'(v); q_a.push_back(model(v, 1'b0));
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Bounded wait for done; returns clocks elapsed since E0.
    task automatic wait_done(input bit sel, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            tick();
            cyc++;
            if (sel ? done_b : done_a) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; bin_a = 14'd0; bin_b = 14'd0;
        repeat (3) tick();
        n_checks++;
        if ({busy_a, done_a, ovf_a, bcd_a} !== 19'd0) begin
            n_fail++; $display("FAIL reset_a: got %h expected %h", {busy_a, done_a, ovf_a, bcd_a}, 19'd0);
        end
        n_checks++;
        if ({busy_b, done_b, ovf_b, bcd_b} !== 19'd0) begin
            n_fail++; $display("FAIL reset_b: got %h expected %h", {busy_b, done_b, ovf_b, bcd_b}, 19'd0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    // Plain conversions on the non-blanking instance, latency included.
    task automatic run_list_a(input string name, input int vals[3], input int n);
        int cyc; bit seen; logic [16:0] exp;
        for (int i = 0; i < n; i++) begin
            start_conv(1'b0, vals[i]);
            n_checks++;
            if (busy_a !== 1'b1) begin
                n_fail++; $display("FAIL %s_busy_after_start: got %b expected 1", name, busy_a);
            end
            wait_done(1'b0, cyc, seen);
            n_checks++;
            if (!seen || cyc != 15) begin
                n_fail++; $display("FAIL %s_latency: got %0d expected 15 (seen=%b)", name, cyc, seen);
            end
            exp = q_a.pop_front();
            n_checks++;
            if ({ovf_a, bcd_a} !== exp) begin
                n_fail++; $display("FAIL %s_result bin=%0d: got %h expected %h", name, vals[i], {ovf_a, bcd_a}, exp);
            end
            n_checks++;
            if (busy_a !== 1'b0) begin
                n_fail++; $display("FAIL %s_busy_at_done: got %b expected 0", name, busy_a);
            end
            tick();
        end
    endtask

    task automatic test_basic();
        int vals[3] = '{0, 9999, 0};
        run_list_a("basic", vals, 2);
    endtask

    task automatic test_range();
        int vals[3] = '{10000, 16383, 7};
        run_list_a("range", vals, 3);
    endtask

    task automatic test_lzb();
        int vals[3] = '{42, 0, 1005};
        logic [15:0] lit[3] = '{16'hFF42, 16'hFFF0, 16'h1005};
        int cyc; bit seen; logic [16:0] exp;
        for (int i = 0; i < 3; i++) begin
            start_conv(1'b1, vals[i]);
            wait_done(1'b1, cyc, seen);
            exp = q_b.pop_front();
            n_checks++;
            if (!seen || {ovf_b, bcd_b} !== exp || bcd_b !== lit[i]) begin
                n_fail++; $display("FAIL lzb bin=%0d: got %h expected %h (seen=%b)", vals[i], {ovf_b, bcd_b}, {1'b0, lit[i]}, seen);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int cyc; bit seen; logic [16:0] exp; int hold_bad;
        start_conv(1'b0, 1234);
        wait_done(1'b0, cyc, seen);
        exp = q_a.pop_front();
        n_checks++;
        if (!seen || {ovf_a, bcd_a} !== exp) begin
            n_fail++; $display("FAIL b2b_first: got %h expected %h (seen=%b)", {ovf_a, bcd_a}, exp, seen);
        end
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL b2b_busy_done_cycle: got %b expected 0", busy_a);
        end
        start_conv(1'b0, 5678);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL b2b_accept_in_done: got busy %b expected 1", busy_a);
        end
        hold_bad = 0; cyc = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            if (bcd_a !== 16'h1234 || busy_a !== 1'b1) hold_bad++;
            tick();
            cyc++;
            if (done_a) seen = 1'b1;
        end
        n_checks++;
        if (hold_bad != 0) begin
            n_fail++; $display("FAIL b2b_hold: got %0d bad cycles expected 0", hold_bad);
        end
        exp = q_a.pop_front();
        n_checks++;
        if (!seen || cyc != 15 || {ovf_a, bcd_a} !== exp) begin
            n_fail++; $display("FAIL b2b_second: got %h after %0d expected %h after 15", {ovf_a, bcd_a}, cyc, exp);
        end
        tick();
    endtask

    task automatic test_ignore_busy();
        int n_done; logic [16:0] exp; logic [16:0] got;
        start_conv(1'b0, 4321);
        n_done = 0;
        got = 17'd0;
        for (int i = 0; i < 14; i++) begin
            start_a = (i % 3 != 2);
            bin_a   = 14'($urandom_range(0, 16383));
            tick();
            if (done_a) n_done++;
        end
        start_a = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done_a) begin
                n_done++;
                got = {ovf_a, bcd_a};
            end
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", n_done);
        end
        exp = q_a.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++; $display("FAIL ignore_result: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen; logic [16:0] exp; int n_done;
        start_conv(1'b0, 321);
        wait_done(1'b0, cyc, seen);
        exp = q_a.pop_front();
        n_checks++;
        if (!seen || {ovf_a, bcd_a} !== exp) begin
            n_fail++; $display("FAIL rstmid_pre: got %h expected %h (seen=%b)", {ovf_a, bcd_a}, exp, seen);
        end
        tick();
        start_conv(1'b0, 999);
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        q_a.delete();
        n_checks++;
        if ({busy_a, done_a, ovf_a, bcd_a} !== 19'd0) begin
            n_fail++; $display("FAIL rstmid_async: got %h expected %h", {busy_a, done_a, ovf_a, bcd_a}, 19'd0);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done_a) n_done++;
        end
        n_checks++;
        if (n_done != 0 || bcd_a !== 16'h0000) begin
            n_fail++; $display("FAIL rstmid_no_done: got %0d pulses bcd %h expected 0 pulses bcd 0000", n_done, bcd_a);
        end
        start_conv(1'b0, 999);
        wait_done(1'b0, cyc, seen);
        exp = q_a.pop_front();
        n_checks++;
        if (!seen || cyc != 15 || {ovf_a, bcd_a} !== exp || bcd_a !== 16'h0999) begin
            n_fail++; $display("FAIL rstmid_after: got %h after %0d expected %h after 15", {ovf_a, bcd_a}, cyc, exp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_range();
        test_lzb();
        test_ignore_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. It sits directly upstream of the per-digit seven-segment decoders. It converts an unsigned binary count into DIGITS packed BCD nibbles and holds the last result stable so the display never shows intermediate values. Optional leading-zero blanking and out-of-range indication both drive nibble code 4'hF, which the downstream decoder renders as a blank digit.

Parameters:
BIN_W, 14, width of binary input; must satisfy 2^BIN_W >= 10^DIGITS.
DIGITS, 4, number of BCD output digits.
LZB, 0, 1 = replace leading zero digits with 4'hF; the least significant digit is never blanked.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a conversion; sampled only in IDLE.
bin  input  BIN_W  unsigned value, captured on the accepted start edge.
busy  output  1  high while a conversion is in progress.
done  output  1  single-cycle pulse when bcd/ovf are updated.
ovf  output  1  last captured value exceeded 10^DIGITS-1.
bcd  output  4*DIGITS  packed result; digit 0 is bits [3:0] (LS digit).

Behaviour:
- Clock and reset: single clock clk. Reset is asynchronous, active-low, on rst_n. Reset forces state IDLE, busy=0, done=0, ovf=0, bcd=0, and clears the internal shift register and bit counter.
- States:
  - IDLE: waits for start.
  - SHIFT: performs BIN_W iterations.
  - LOAD: publishes the result.
- IDLE:
  - start=1 at edge E0 captures bin into the shift register, clears the BCD accumulator and counter, and enters SHIFT.
  - Also at E0, a range flag is latched: bin > 10^DIGITS-1. The limit is a localparam computed at elaboration.
- SHIFT, edges E1..E_BIN_W, one iteration per edge:
  - Every accumulator nibble >= 5 gets +3 (4-bit add, no carry into the next nibble).
  - Then {accumulator, shift register} shifts left by 1.
  - After the BIN_W-th iteration, go to LOAD.
- LOAD, edge E_(BIN_W+1):
  - bcd is loaded. If the range flag is set: bcd = all nibbles 4'hF and ovf=1. Otherwise: bcd = accumulator (with LZB applied) and ovf=0.
  - done=1 for exactly this one cycle; busy=0; return to IDLE.
- Latency: done is high in the cycle following edge E_(BIN_W+1), i.e. BIN_W+1 clocks after the start edge. Default is 15 clocks.
- busy: high after E0 through E_BIN_W, low after E_(BIN_W+1). Throughput is one conversion per BIN_W+2 clocks minimum.
- start while busy (SHIFT/LOAD): ignored. No queuing; bin changes during conversion have no effect.
- start in the cycle done is high: accepted, because state is already IDLE. Back-to-back conversion is legal.
- bcd and ovf change only at LOAD and hold otherwise. Intermediate accumulator values never appear on bcd.
- LZB=1: scanning from the MS digit down, each zero nibble becomes 4'hF until the first nonzero digit. Digit 0 always shows its value, so 0 displays as a single "0". LZB has no effect when ovf=1.
- Reset mid-conversion: the conversion is aborted immediately. Outputs go to reset values; no done pulse is produced.
- bin wider than needed: handled by the range flag. The accumulator only needs DIGITS nibbles because out-of-range results are discarded.

Test Plan:
- BIN_W=14, DIGITS=4, LZB=0: bin=0, then start -> done exactly 15 clocks after the start edge, bcd=16'h0000, ovf=0. Next, bin=9999 -> bcd=16'h9999, ovf=0.
- bin=1234, then 5678 back-to-back, with start asserted in the done cycle -> bcd=16'h1234, then 16'h5678. busy stays low for only the done cycle. bcd holds 16'h1234 throughout the second conversion.
- bin=10000 -> ovf=1, bcd=16'hFFFF. Then bin=16383 -> ovf=1, bcd=16'hFFFF. Then bin=7 -> ovf=0, bcd=16'h0007.
- LZB=1: bin=42 -> bcd=16'hFF42; bin=0 -> bcd=16'hFFF0; bin=1005 -> bcd=16'h1005 (interior zeros are kept).
- start pulses during busy with bin changing -> ignored; result reflects the value captured at E0; exactly one done pulse per accepted start.
- Complete bin=321. Then start bin=999 and assert rst_n=0 asynchronously at E7 -> busy=0, done=0, bcd=0, ovf=0 immediately, with no later done. After release, a new conversion with bin=999 gives 16'h0999.
